// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART arbiter definitions: FSM encoding and default sizing.
package uart_tx_arbiter_pkg;

  localparam int UART_NUM_REQ_DEF = 4;
  localparam int UART_TO_W_DEF    = 18;
  localparam int OWNER_W          = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin requester picker: first set request bit above last_grant, wrapping.
module rr_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = UART_NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] last_grant,
  output logic               valid,
  output logic [OWNER_W-1:0] winner
);

  int                 w_idx;
  logic [NUM_REQ-1:0] w_shifted;

  always_comb begin
    valid     = 1'b0;
    winner    = '0;
    w_idx     = 0;
    w_shifted = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = int'(last_grant) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      // Shift instead of indexing so the candidate bit lands at position 0.
      w_shifted = req >> w_idx;
      if (!valid && w_shifted[0]) begin
        valid  = 1'b1;
        winner = OWNER_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters with round-robin grants and a completion watchdog.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = UART_NUM_REQ_DEF,
  parameter int TO_W    = UART_TO_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arb_en,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic                 tx_en,
  input  logic                 tx_done,
  input  logic                 tx_busy,
  output logic [OWNER_W-1:0]   owner,
  output logic                 active,
  output logic                 err
);

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [OWNER_W-1:0] r_last;
  logic [OWNER_W-1:0] r_owner;
  logic [7:0]         r_tx_data;
  logic [TO_W-1:0]    r_wd;

  logic               w_pick_valid;
  logic [OWNER_W-1:0] w_pick_idx;
  logic [7:0]         w_pick_byte;
  logic               w_launch;
  logic               w_finish;
  logic               w_wd_full;
  logic [NUM_REQ-1:0] w_onehot;

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_picker (
    .req       (req),
    .last_grant(r_last),
    .valid     (w_pick_valid),
    .winner    (w_pick_idx)
  );

  assign w_pick_byte = 8'(req_data >> {w_pick_idx, 3'b000});
  assign w_launch    = (r_state == ST_IDLE) && arb_en && w_pick_valid && !tx_busy;
  assign w_wd_full   = &r_wd;
  assign w_finish    = (r_state == ST_WAIT_DONE) && (tx_done || w_wd_full);
  assign w_onehot    = NUM_REQ'(1) << r_owner;
  assign tx_data     = r_tx_data;
  assign owner       = r_owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_last    <= OWNER_W'(NUM_REQ - 1);
      r_owner   <= '0;
      r_tx_data <= '0;
      r_wd      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_launch) begin
        r_owner   <= w_pick_idx;
        r_tx_data <= w_pick_byte;
      end
      // The watchdog saturates at all-ones; that value itself ends the frame.
      if (r_state == ST_LAUNCH) begin
        r_wd <= '0;
      end else if (r_state == ST_WAIT_DONE && !w_wd_full) begin
        r_wd <= r_wd + TO_W'(1);
      end
      if (w_finish) r_last <= r_owner;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    gnt         = '0;
    tx_start    = 1'b0;
    tx_en       = 1'b0;
    active      = 1'b0;
    err         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) w_state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        gnt         = w_onehot;
        tx_start    = 1'b1;
        tx_en       = 1'b1;
        active      = 1'b1;
        w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        tx_en  = 1'b1;
        active = 1'b1;
        // A done arriving with the timeout wins, so no error is flagged.
        if (tx_done) begin
          w_state_nxt = ST_IDLE;
        end else if (w_wd_full) begin
          err         = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level model compared every cycle plus directed literal checks.
module tb_uart_tx_arbiter;

  localparam int N      = 4;
  localparam int TO_W   = 18;
  localparam int WD_MAX = (1 << TO_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n    = 1'b0;
  logic           arb_en   = 1'b0;
  logic [N-1:0]   req      = '0;
  logic [N*8-1:0] req_data = '0;
  logic           tx_done  = 1'b0;
  logic           tx_busy  = 1'b0;
  logic [N-1:0]   gnt;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_en;
  logic [2:0]     owner;
  logic           active;
  logic           err;

  logic           b_arb_en   = 1'b0;
  logic [N-1:0]   b_req      = '0;
  logic [N*8-1:0] b_req_data = '0;
  logic           b_tx_done  = 1'b0;
  logic           b_tx_busy  = 1'b0;
  logic [N-1:0]   b_gnt;
  logic           b_tx_start;
  logic [7:0]     b_tx_data;
  logic           b_tx_en;
  logic [2:0]     b_owner;
  logic           b_active;
  logic           b_err;

  uart_tx_arbiter #(.NUM_REQ(N), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req), .req_data(req_data),
    .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data), .tx_en(tx_en),
    .tx_done(tx_done), .tx_busy(tx_busy), .owner(owner), .active(active), .err(err)
  );

  uart_tx_arbiter #(.NUM_REQ(N), .TO_W(4)) dut_wd (
    .clk(clk), .rst_n(rst_n), .arb_en(b_arb_en), .req(b_req), .req_data(b_req_data),
    .gnt(b_gnt), .tx_start(b_tx_start), .tx_data(b_tx_data), .tx_en(b_tx_en),
    .tx_done(b_tx_done), .tx_busy(b_tx_busy), .owner(b_owner), .active(b_active), .err(b_err)
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a transfer is "in flight" from grant until done/timeout.
  bit         m_act    = 1'b0;
  bit         m_launch = 1'b0;
  int         m_wait   = 0;
  int         m_last   = N - 1;
  int         m_owner  = 0;
  logic [7:0] m_data   = '0;
  int         m_w;
  int         m_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 1'b0; m_launch = 1'b0; m_wait = 0;
      m_last = N - 1; m_owner = 0; m_data = '0;
    end else if (!m_act) begin
      if (arb_en && req != 0 && !tx_busy) begin
        m_w = -1;
        for (int k = 1; k <= N; k++) begin
          m_c = (m_last + k) % N;
          if (m_w < 0 && ((req >> m_c) & 1) != 0) m_w = m_c;
        end
        m_owner = m_w;
        m_data = 8'(req_data >> (8 * m_w));
        m_act = 1'b1;
        m_launch = 1'b1;
      end
    end else if (m_launch) begin
      m_launch = 1'b0;
      m_wait = 0;
    end else if (tx_done || m_wait == WD_MAX) begin
      m_act = 1'b0;
      m_last = m_owner;
    end else begin
      m_wait++;
    end
  end

  always @(negedge clk) begin
    chk("gnt", 32'(gnt), m_launch ? (32'd1 << m_owner) : 32'd0);
    chk("tx_start", 32'(tx_start), 32'(m_launch));
    chk("tx_en", 32'(tx_en), 32'(m_act));
    chk("active", 32'(active), 32'(m_act));
    chk("tx_data", 32'(tx_data), 32'(m_data));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("err", 32'(err), 32'(m_act && !m_launch && m_wait == WD_MAX && !tx_done));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    step(1);
    tx_done = 1'b0;
  endtask

  task automatic wait_gnt(input string nm, input bit sel, input int lim, output int got);
    logic [N-1:0] g;
    got = -1;
    for (int i = 0; i < lim; i++) begin
      step(1);
      g = sel ? b_gnt : gnt;
      if (g != 0) begin
        for (int b = 0; b < N; b++) if (g[b]) got = b;
        break;
      end
    end
    if (got < 0) begin
      n_chk++;
      n_bad++;
      $display("FAIL %s: no grant within %0d cycles", nm, lim);
    end
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL global_timeout: bench did not finish");
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1);
  end

  int exp_ord[5]           = '{0, 1, 2, 3, 0};
  logic [7:0] exp_byte[5]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
  int w;
  int g0;
  int done_cyc;

  initial begin
    step(3);
    chk("rst gnt", 32'(gnt), 0);
    chk("rst tx_start", 32'(tx_start), 0);
    chk("rst tx_data", 32'(tx_data), 0);
    chk("rst tx_en", 32'(tx_en), 0);
    chk("rst owner", 32'(owner), 0);
    chk("rst active", 32'(active), 0);
    chk("rst err", 32'(err), 0);
    rst_n = 1'b1;
    arb_en = 1'b1;

    // Single request from requester 2, done 20 cycles after grant
    req_data = {8'h3C, 8'hA5, 8'h5A, 8'h11};
    req = 4'b0100;
    step(1);
    chk("A gnt", 32'(gnt), 32'h4);
    chk("A tx_start", 32'(tx_start), 1);
    chk("A tx_data", 32'(tx_data), 32'hA5);
    chk("A owner", 32'(owner), 2);
    req = '0;
    step(20);
    chk("A busy before done", 32'(active), 1);
    pulse_done();
    chk("A idle after done", 32'(active), 0);
    chk("A tx_data held", 32'(tx_data), 32'hA5);

    // All four requesting continuously from reset
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'hF;
    done_cyc = 0;
    for (int i = 0; i < 5; i++) begin
      wait_gnt("B grant", 1'b0, 4, w);
      chk("B order", 32'(w), 32'(exp_ord[i]));
      chk("B byte", 32'(tx_data), 32'(exp_byte[i]));
      if (i > 0) chk("B done-to-start", 32'(cyc - done_cyc), 2);
      step(3);
      done_cyc = cyc;
      pulse_done();
    end
    req = '0;
    step(2);

    // Transmitter busy blocks the grant until it falls
    tx_busy = 1'b1;
    req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("C held off", 32'(gnt), 0);
    end
    tx_busy = 1'b0;
    step(1);
    chk("C gnt", 32'(gnt), 32'h2);
    chk("C owner", 32'(owner), 1);
    req = '0;
    step(2);
    pulse_done();

    // Withdrawn request skipped; done ignored in LAUNCH; arb_en low mid-frame
    arb_en = 1'b0;
    req = 4'b1100;
    step(2);
    req = 4'b1000;
    arb_en = 1'b1;
    step(1);
    chk("D skip gnt", 32'(gnt), 32'h8);
    tx_done = 1'b1;
    step(1);
    tx_done = 1'b0;
    chk("D done ignored in launch", 32'(active), 1);
    arb_en = 1'b0;
    req = 4'b0001;
    step(3);
    pulse_done();
    chk("D frame completes", 32'(active), 0);
    step(3);
    chk("D no grant arb_en=0", 32'(gnt), 0);
    arb_en = 1'b1;
    step(1);
    chk("D gnt after enable", 32'(gnt), 32'h1);
    req = '0;
    step(2);
    pulse_done();

    // Reset in WAIT_DONE
    req = 4'b0100;
    step(1);
    chk("E gnt", 32'(gnt), 32'h4);
    step(4);
    #2 rst_n = 1'b0;
    #1;
    chk("E rst active", 32'(active), 0);
    chk("E rst tx_en", 32'(tx_en), 0);
    chk("E rst tx_data", 32'(tx_data), 0);
    chk("E rst owner", 32'(owner), 0);
    chk("E rst gnt", 32'(gnt | N'(tx_start) | N'(err)), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req = 4'hF;
    step(1);
    chk("E first gnt after reset", 32'(gnt), 32'h1);
    req = '0;
    step(2);
    pulse_done();

    // Watchdog with TO_W=4: timeout, then coincident done
    b_arb_en = 1'b1;
    b_req_data = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    b_req = 4'b0011;
    wait_gnt("F grant", 1'b1, 4, w);
    g0 = cyc;
    chk("F first owner", 32'(w), 0);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      chk("F err timing", 32'(b_err), (k == 16) ? 1 : 0);
    end
    step(1);
    chk("F idle after err", 32'(b_active), 0);
    chk("F err one cycle", 32'(b_err), 0);
    step(1);
    chk("F next gnt owner+1", 32'(b_gnt), 32'h2);
    chk("F owner", 32'(b_owner), 1);
    chk("F latency", 32'(cyc - g0), 18);
    step(15);
    chk("F no early err", 32'(b_err), 0);
    step(1);
    b_tx_done = 1'b1;
    #1;
    chk("G done beats timeout", 32'(b_err), 0);
    step(1);
    b_tx_done = 1'b0;
    chk("G idle after done", 32'(b_active), 0);
    step(1);
    chk("G next gnt", 32'(b_gnt), 32'h1);
    b_req = '0;
    step(20);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one UART transmitter (range 2..8).
REQ-002 The block SHALL have parameter TO_W, default 18, giving the width of the completion watchdog counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port arb_en, input, 1 bit: high allows new grants; low blocks new grants only.
REQ-006 The block SHALL have port req, input, NUM_REQ bits: per-requester level request; hold until granted.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*8 bits: byte i on bits [8i+7:8i].
REQ-008 The block SHALL have port gnt, output, NUM_REQ bits: one-hot, one-cycle acknowledge that the byte was taken.
REQ-009 The block SHALL have port tx_start, output, 1 bit: one-cycle start pulse to the transmitter.
REQ-010 The block SHALL have port tx_data, output, 8 bits: latched byte to the transmitter, stable from LAUNCH until return to IDLE.
REQ-011 The block SHALL have port tx_en, output, 1 bit: transmitter enable, high whenever state is not IDLE.
REQ-012 The block SHALL have port tx_done, input, 1 bit: one-cycle frame-complete pulse from the transmitter.
REQ-013 The block SHALL have port tx_busy, input, 1 bit: transmitter is busy.
REQ-014 The block SHALL have port owner, output, 3 bits: index of the current or last granted requester.
REQ-015 The block SHALL have port active, output, 1 bit: high when state is not IDLE.
REQ-016 The block SHALL have port err, output, 1 bit: one-cycle pulse on watchdog timeout.

Function
REQ-017 The FSM SHALL have states IDLE, LAUNCH and WAIT_DONE.
REQ-018 IDLE SHALL go to LAUNCH when arb_en=1, |req=1 and tx_busy=0; otherwise IDLE SHALL hold.
REQ-019 On the IDLE->LAUNCH edge, the winner SHALL be round-robin: first set req bit searching upward from last_grant+1, modulo NUM_REQ.
REQ-020 On the IDLE->LAUNCH edge, the winner byte SHALL be latched into tx_data and the winner index into owner.
REQ-021 In LAUNCH, gnt[owner] and tx_start SHALL be high for exactly that one cycle, and the next state SHALL be WAIT_DONE.
REQ-022 Latency SHALL be 1 cycle: req sampled in IDLE at edge n gives gnt and tx_start visible in cycle n+1.
REQ-023 In WAIT_DONE, tx_done=1 SHALL go to IDLE and set last_grant=owner.
REQ-024 WAIT_DONE SHALL increment the watchdog each cycle, cleared on entry.
REQ-025 A watchdog reaching all-ones SHALL pulse err for one cycle, go to IDLE and set last_grant=owner.
REQ-026 tx_done and watchdog all-ones in the same cycle SHALL be treated as done, with no err.
REQ-027 tx_done SHALL be ignored in IDLE and in LAUNCH.
REQ-028 Back-to-back transfers SHALL be possible: at minimum one IDLE cycle between tx_done and the next tx_start.
REQ-029 A requester that deasserts req before its grant SHALL be skipped without side effect; deassertion after grant SHALL have no effect.
REQ-030 arb_en falling while not IDLE SHALL let the in-flight frame complete normally.
REQ-031 The counter width SHALL be TO_W bits, wrapping is impossible because all-ones terminates; owner width SHALL be fixed at 3 bits, zero-extended.

Reset
REQ-032 rst_n low SHALL asynchronously force: state=IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority), gnt=0, tx_start=0, tx_data=0, tx_en=0, owner=0, active=0, err=0, watchdog=0.
REQ-033 Reset mid-frame SHALL abandon the transfer with no gnt, err or tx_start on release; the first post-reset grant SHALL follow REQ-018 normally.

Structure
REQ-034 State encoding, default NUM_REQ and default TO_W SHALL live in the shared UART package.
REQ-035 One combinational sub-module, rr_picker (inputs req, last_grant; outputs valid, winner index), SHALL implement REQ-019.

Verification
REQ-036 Single request: req=4'b0100, req_data byte2=8'hA5, with tx_done 20 cycles later -> gnt=4'b0100 and tx_start in the same cycle, tx_data=8'hA5, owner=2, IDLE after done.
REQ-037 All four requesting continuously from reset -> grant order 0,1,2,3,0, with tx_start spaced by done+2 cycles.
REQ-038 tx_busy=1 with req pending -> no grant until tx_busy falls, then grant next cycle.
REQ-039 TO_W=4 and no tx_done -> err pulses after 15 WAIT_DONE cycles, then IDLE, and the next grant goes to owner+1.
REQ-040 rst_n asserted in WAIT_DONE -> all outputs 0 immediately, and requester 0 is granted first after release.
REQ-041 tx_done coincident with watchdog all-ones -> err=0 and normal completion.
